// File: rtl/set_job_sched.sv
// set_job_sched: arbitrates SET evaluation jobs from two requesters onto one
// shared 4-MapCell SET engine. The winner's mode and circle configuration are
// latched and held for the engine. After a settle period the engine is started.
// The candidate count is returned to the winner, or the job is aborted if the
// engine never answers.

module set_job_sched #(
    parameter int CFG_W    = 24,
    parameter int LOAD_CYC = 2,
    parameter int TIMEOUT  = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       mode_0,
    input  logic [1:0]       mode_1,
    input  logic [CFG_W-1:0] cfg_0,
    input  logic [CFG_W-1:0] cfg_1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [1:0]       err,
    output logic [7:0]       result,
    output logic             eng_en,
    output logic [1:0]       eng_mode,
    output logic [CFG_W-1:0] eng_cfg,
    input  logic             eng_busy,
    input  logic             eng_valid,
    input  logic [7:0]       eng_candidate,
    output logic [7:0]       jobs_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0] LOAD_LAST = 3'(LOAD_CYC - 1);
    localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

    state_t           state, state_nxt;
    logic [1:0]       gnt_nxt, done_nxt, err_nxt;
    logic [7:0]       result_nxt, jobs_done_nxt;
    logic             eng_en_nxt;
    logic [1:0]       eng_mode_nxt;
    logic [CFG_W-1:0] eng_cfg_nxt;
    logic [7:0]       timer, timer_nxt;
    logic [2:0]       load_cnt, load_cnt_nxt;
    logic             ptr, ptr_nxt;
    logic             owner, owner_nxt;
    logic             win;

    // Round-robin pick: a lone request wins outright, a tie goes to the pointer.
    always_comb begin
        win = 1'b0;
        if (req == 2'b11) begin
            win = ptr;
        end else if (req[1]) begin
            win = 1'b1;
        end
    end

    // Next-state and next-output logic. Every output is registered, so each one is computed here as a next value.
    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        done_nxt      = 2'b00;
        err_nxt       = 2'b00;
        result_nxt    = result;
        jobs_done_nxt = jobs_done;
        eng_en_nxt    = 1'b0;
        eng_mode_nxt  = eng_mode;
        eng_cfg_nxt   = eng_cfg;
        timer_nxt     = timer;
        load_cnt_nxt  = load_cnt;
        ptr_nxt       = ptr;
        owner_nxt     = owner;

        case (state)
            S_IDLE: begin
                if ((|req) && !eng_busy) begin
                    owner_nxt    = win;
                    gnt_nxt      = win ? 2'b10 : 2'b01;
                    eng_mode_nxt = win ? mode_1 : mode_0;
                    eng_cfg_nxt  = win ? cfg_1 : cfg_0;
                    load_cnt_nxt = 3'd0;
                    state_nxt    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_cnt == LOAD_LAST) begin
                    if (!eng_busy) begin
                        eng_en_nxt = 1'b1;
                        timer_nxt  = 8'd0;
                        state_nxt  = S_START;
                    end
                end else begin
                    load_cnt_nxt = load_cnt + 3'd1;
                end
            end
            S_START: begin
                timer_nxt = timer + 8'd1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (eng_valid) begin
                    result_nxt    = eng_candidate;
                    jobs_done_nxt = jobs_done + 8'd1;
                    done_nxt      = gnt;
                    ptr_nxt       = ~owner;
                    state_nxt     = S_DONE;
                end else if (timer == TIMEOUT_V) begin
                    err_nxt   = gnt;
                    ptr_nxt   = ~owner;
                    state_nxt = S_ERR;
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end
            S_DONE, S_ERR: begin
                gnt_nxt   = 2'b00;
                state_nxt = S_IDLE;
            end
            default: begin
                gnt_nxt   = 2'b00;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops any job in flight without a done or err pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt       <= 2'b00;
            done      <= 2'b00;
            err       <= 2'b00;
            result    <= 8'd0;
            jobs_done <= 8'd0;
            eng_en    <= 1'b0;
            eng_mode  <= 2'b00;
            eng_cfg   <= '0;
            timer     <= 8'd0;
            load_cnt  <= 3'd0;
            ptr       <= 1'b0;
            owner     <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            result    <= result_nxt;
            jobs_done <= jobs_done_nxt;
            eng_en    <= eng_en_nxt;
            eng_mode  <= eng_mode_nxt;
            eng_cfg   <= eng_cfg_nxt;
            timer     <= timer_nxt;
            load_cnt  <= load_cnt_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
        end
    end

endmodule

// File: doc/set_job_sched.md
Name: set_job_sched

Overview:
- Schedules SET evaluation jobs from two requesters onto one shared 4-MapCell SET engine.
- Arbitrates round-robin and latches the winner's mode and circle configuration.
- Holds the configuration stable for the engine, issues the start pulse, waits for the engine's valid, and returns the candidate count to the winner.
- Sits between the host-side job ports and the engine's control FSM; a watchdog recovers from a hung engine.

Parameters:
- CFG_W, 24, width of one requester's circle configuration word (three circles x {x[3:0], y[3:0]}).
- LOAD_CYC, 2, cycles the latched configuration is held before the start pulse (MapCell settle time), range 1..7.
- TIMEOUT, 127, maximum RUN-state cycles waiting for eng_valid before abort, range 64..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  job request per requester, level; held until that requester's done or err.
- mode_0  in  2  requester 0 mode: 00 single, 01 AND, 10 XOR, 11 exactly-two-of-three.
- mode_1  in  2  requester 1 mode.
- cfg_0  in  CFG_W  requester 0 circle configuration.
- cfg_1  in  CFG_W  requester 1 circle configuration.
- gnt  out  2  one-hot grant, high from acceptance through the DONE/ERR cycle.
- done  out  2  one-cycle completion pulse to the granted requester.
- err  out  2  one-cycle timeout-abort pulse to the granted requester.
- result  out  8  candidate count of the last completed job; held until the next completion.
- eng_en  out  1  one-cycle engine start pulse.
- eng_mode  out  2  latched mode to the engine.
- eng_cfg  out  CFG_W  latched configuration to the MapCells.
- eng_busy  in  1  engine busy.
- eng_valid  in  1  engine result-valid strobe, one cycle.
- eng_candidate  in  8  engine candidate count, sampled only with eng_valid.
- jobs_done  out  8  completed-job counter, wraps 255->0; aborted jobs are not counted.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; gnt, done, err, eng_en = 0; result, eng_mode, eng_cfg, jobs_done, timer = 0; round-robin pointer = requester 0. A job in progress is dropped with no done and no err.
- FSM states: IDLE, LOAD, START, RUN, DONE, ERR. All outputs are registered.
- IDLE -> LOAD: when any req bit is high and eng_busy=0.
  - Single request: that requester wins.
  - Both requests: the pointer's requester wins.
  - Winner's mode and cfg latch into eng_mode/eng_cfg; gnt goes high the next cycle.
  - While eng_busy=1, stay in IDLE.
- LOAD: eng_cfg and eng_mode are held LOAD_CYC cycles, then -> START.
- START: eng_en=1 for exactly one cycle; timer cleared; -> RUN.
- RUN: timer increments each cycle.
  - eng_valid=1 -> result<=eng_candidate, -> DONE.
  - Else timer==TIMEOUT -> ERR.
  - eng_valid on the timeout cycle: valid wins.
- DONE (one cycle): done[winner]=1, jobs_done+1, pointer<=other requester, -> IDLE.
- ERR (one cycle): err[winner]=1, result unchanged, pointer<=other requester, -> IDLE.
- Latency from acceptance to done: LOAD_CYC + 1 + engine latency + 1 cycles. Minimum re-grant gap is 1 IDLE cycle.
- Boundaries:
  - req deasserted mid-job: ignored; the job completes and done/err still pulses.
  - req changed to another mode or cfg mid-job: ignored (values already latched).
  - eng_valid outside RUN: ignored, no result update.
  - eng_en is never issued while eng_busy=1.
  - Same requester re-requesting immediately while the other waits: the other wins (fairness).

Test Plan:
- Single job: req=01, mode_0=00, engine model valid after 16 cycles with candidate=8'd23 -> eng_en pulse LOAD_CYC+1 cycles after acceptance; done=01 one cycle; result=23; jobs_done=1.
- Contention after reset: req=11 in the same cycle -> gnt=01 first; after done, gnt=10 next; result tracks each job's candidate (e.g. 5 then 40).
- Fairness: requester 0 re-asserts immediately while requester 1 holds req -> requester 1 granted; no requester is served twice in a row while the other waits.
- Timeout: engine never asserts valid -> err pulses exactly TIMEOUT+1 cycles after eng_en; result unchanged; jobs_done unchanged; next request accepted.
- Valid on the timeout cycle: done pulses, not err; result updated.
- Reset mid-RUN: rst pulse -> all outputs 0 immediately; no done/err; pointer=0; eng_busy=1 at the first post-reset request -> no grant until eng_busy=0.
